// File: rtl/req_debounce8_if.sv
// Request-debouncer bus: raw request lines and enable in, debounced vector,
// encoder enable and change-event handshake out.
interface req_debounce8_if;
  logic [7:0] raw;
  logic       en_in;
  logic [7:0] a;
  logic       en;
  logic       vld;
  logic       rdy;
  logic [7:0] chg;
  logic       ovf;

  modport master (
    output raw, en_in, rdy,
    input  a, en, vld, chg, ovf
  );

  modport slave (
    input  raw, en_in, rdy,
    output a, en, vld, chg, ovf
  );
endinterface

// File: rtl/req_debounce8.sv
// Eight-channel request debouncer feeding a downstream 8-to-3 encoder.
// Each raw line is double-flop synchronized, then must disagree with its
// debounced value for DB_CNT consecutive cycles before the value flips.
// Changes of the debounced vector seen while ACTIVE raise a change event
// (vld/chg) held until the consumer accepts it; ovf records a change that
// arrived while an event was still pending.
//
// state  | meaning
// IDLE   | everything cleared, encoder disabled, waiting for en_in
// SETTLE | synchronizer/debounce running, no events, encoder disabled
// ACTIVE | encoder enabled, debounced changes produce events
module req_debounce8 #(
  parameter int DB_CNT = 4
) (
  input logic          clk,
  input logic          rst_n,
  req_debounce8_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  // Terminal count of the per-channel counters, and the settle down-counter
  // load giving DB_CNT+2 cycles in SETTLE (counts load..0 inclusive).
  localparam logic [3:0] CNT_TC     = 4'(DB_CNT - 1);
  localparam logic [4:0] SETTLE_LD  = 5'(DB_CNT + 1);

  state_t          r_state;
  logic [7:0]      r_s1;
  logic [7:0]      r_s2;
  logic [7:0][3:0] r_cnt;
  logic [4:0]      r_settle;
  logic [7:0]      r_a;
  logic            r_en;
  logic            r_vld;
  logic [7:0]      r_chg;
  logic            r_ovf;

  logic [7:0]      w_a_next;
  logic [7:0][3:0] w_cnt_next;
  logic [7:0]      w_flip;

  // Per-channel debounce next state: count disagreement, flip at terminal count.
  always_comb begin
    w_a_next   = r_a;
    w_cnt_next = '0;
    w_flip     = '0;
    for (int i = 0; i < 8; i++) begin
      if (r_s2[i] != r_a[i]) begin
        if (r_cnt[i] == CNT_TC) begin
          w_a_next[i] = r_s2[i];
          w_flip[i]   = 1'b1;
        end else begin
          w_cnt_next[i] = r_cnt[i] + 4'd1;
        end
      end
    end
  end

  // Sequencing FSM with synchronizer, debounce state and event registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_s1     <= '0;
      r_s2     <= '0;
      r_cnt    <= '0;
      r_settle <= '0;
      r_a      <= '0;
      r_en     <= 1'b0;
      r_vld    <= 1'b0;
      r_chg    <= '0;
      r_ovf    <= 1'b0;
    end else if (!bus.en_in) begin
      // Disable wins from any state and clears everything on this edge.
      r_state  <= S_IDLE;
      r_s1     <= '0;
      r_s2     <= '0;
      r_cnt    <= '0;
      r_settle <= '0;
      r_a      <= '0;
      r_en     <= 1'b0;
      r_vld    <= 1'b0;
      r_chg    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_s1     <= '0;
          r_s2     <= '0;
          r_cnt    <= '0;
          r_a      <= '0;
          r_en     <= 1'b0;
          r_vld    <= 1'b0;
          r_chg    <= '0;
          r_ovf    <= 1'b0;
          r_settle <= SETTLE_LD;
          r_state  <= S_SETTLE;
        end

        S_SETTLE: begin
          r_s1  <= bus.raw;
          r_s2  <= r_s1;
          r_cnt <= w_cnt_next;
          r_a   <= w_a_next;
          if (r_settle == 5'd0) begin
            r_state <= S_ACTIVE;
            r_en    <= 1'b1;
          end else begin
            r_settle <= r_settle - 5'd1;
          end
        end

        S_ACTIVE: begin
          r_s1  <= bus.raw;
          r_s2  <= r_s1;
          r_cnt <= w_cnt_next;
          r_a   <= w_a_next;
          r_en  <= 1'b1;
          if (|w_flip) begin
            r_vld <= 1'b1;
            if (!r_vld || bus.rdy) begin
              // Fresh event, or pending one accepted on this same edge:
              // report only the bits changing now.
              r_chg <= w_flip;
            end else begin
              r_chg <= r_chg | w_flip;
              r_ovf <= 1'b1;
            end
          end else if (r_vld && bus.rdy) begin
            r_vld <= 1'b0;
            r_chg <= '0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a   = r_a;
  assign bus.en  = r_en;
  assign bus.vld = r_vld;
  assign bus.chg = r_chg;
  assign bus.ovf = r_ovf;

endmodule

// File: tb/tb_req_debounce8.sv
// Directed bench for req_debounce8 (DB_CNT=4): vector table for the basic
// debounce/handshake behaviour, hand sequences for the multi-cycle cases.
module tb_req_debounce8;

  logic clk;
  logic rst_n;

  req_debounce8_if bus ();

  req_debounce8 #(.DB_CNT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] raw;
    logic       rdy;
    logic [7:0] a;
    logic       vld;
    logic [7:0] chg;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, want %02h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, want %0b", name, act, exp);
    end
  endtask

  // chg only compared when it is meaningful (vld expected high) or forced.
  task automatic chk_all(input string tag, input logic [7:0] ea, input logic een,
                         input logic evld, input logic [7:0] echg, input logic eovf,
                         input logic force_chg);
    chk8({tag, " a"}, bus.a, ea);
    chk1({tag, " en"}, bus.en, een);
    chk1({tag, " vld"}, bus.vld, evld);
    if (evld || force_chg) chk8({tag, " chg"}, bus.chg, echg);
    chk1({tag, " ovf"}, bus.ovf, eovf);
  endtask

  initial begin
    // raw 00->05 from edge 1: flips at edge 6, accepted at edge 8
    vecs.push_back('{8'h05, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h05, 1'b1, 8'h05});
    vecs.push_back('{8'h05, 1'b0, 8'h05, 1'b1, 8'h05});
    vecs.push_back('{8'h05, 1'b1, 8'h05, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h05, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b1, 8'h05, 1'b0, 8'h00});
    // raw[3] glitch for 3 cycles: filtered
    vecs.push_back('{8'h0D, 1'b0, 8'h05, 1'b0, 8'h00});
    vecs.push_back('{8'h0D, 1'b0, 8'h05, 1'b0, 8'h00});
    vecs.push_back('{8'h0D, 1'b0, 8'h05, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h05, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h05, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h05, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h05, 1'b0, 8'h00});
    // raw[3] high for exactly 4 cycles: passes, then returns 4 cycles later
    vecs.push_back('{8'h0D, 1'b0, 8'h05, 1'b0, 8'h00});
    vecs.push_back('{8'h0D, 1'b0, 8'h05, 1'b0, 8'h00});
    vecs.push_back('{8'h0D, 1'b0, 8'h05, 1'b0, 8'h00});
    vecs.push_back('{8'h0D, 1'b0, 8'h05, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h05, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h0D, 1'b1, 8'h08});
    vecs.push_back('{8'h05, 1'b1, 8'h0D, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h0D, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h0D, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h05, 1'b1, 8'h08});
    vecs.push_back('{8'h05, 1'b1, 8'h05, 1'b0, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h05, 1'b0, 8'h00});

    rst_n     = 1'b0;
    bus.raw   = 8'h00;
    bus.en_in = 1'b0;
    bus.rdy   = 1'b0;

    #1;
    chk_all("reset", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    run(2);
    chk_all("reset_hold", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    rst_n = 1'b1;
    step();
    chk_all("idle", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Enable: IDLE->SETTLE on this edge, en rises DB_CNT+2 edges later.
    bus.en_in = 1'b1;
    step();
    chk1("settle_entry en", bus.en, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk1($sformatf("settle%0d en", k), bus.en, (k == 6));
      chk8($sformatf("settle%0d a", k), bus.a, 8'h00);
      chk1($sformatf("settle%0d vld", k), bus.vld, 1'b0);
    end

    foreach (vecs[i]) begin
      bus.raw = vecs[i].raw;
      bus.rdy = vecs[i].rdy;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].a, 1'b1, vecs[i].vld, vecs[i].chg, 1'b0, 1'b0);
    end

    // Back to a=00, accept the event.
    bus.raw = 8'h00;
    run(5);
    chk8("clr_pre a", bus.a, 8'h05);
    step();
    chk_all("clr", 8'h00, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
    bus.rdy = 1'b1;
    step();
    chk1("clr_ack vld", bus.vld, 1'b0);
    bus.rdy = 1'b0;

    // 00->01 then 01->03 without accept: chg accumulates, ovf sets.
    bus.raw = 8'h01;
    run(6);
    chk_all("ev01", 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    bus.raw = 8'h03;
    run(5);
    chk_all("ev03_pre", 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    step();
    chk_all("ev03", 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0);

    // Accept coincides with 03->07: chg replaced by new bits only.
    bus.raw = 8'h07;
    run(5);
    chk_all("ev07_pre", 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0);
    bus.rdy = 1'b1;
    step();
    chk_all("ev07", 8'h07, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0);
    bus.rdy = 1'b0;
    step();
    chk_all("ev07_hold", 8'h07, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0);
    bus.rdy = 1'b1;
    step();
    chk_all("ev07_ack", 8'h07, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    bus.rdy = 1'b0;

    // a=81 pending, then disable: everything clears on the next edge.
    bus.raw = 8'h81;
    run(6);
    chk_all("ev81", 8'h81, 1'b1, 1'b1, 8'h86, 1'b1, 1'b0);
    bus.en_in = 1'b0;
    step();
    chk_all("disable", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Re-enable: SETTLE repeats; a settles to 81 with no event.
    bus.en_in = 1'b1;
    step();
    chk_all("reen_entry", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    run(5);
    chk_all("reen_settle", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk_all("reen_active", 8'h81, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk_all("reen_quiet", 8'h81, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Async reset in the middle of a debounce (counter at 2).
    bus.raw = 8'h00;
    run(4);
    chk8("mid_db a", bus.a, 8'h81);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
